// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract operand staging path.
//   DATA_W      : operand width; must match the downstream adder width.
//   MODE_ADD    : mode encoding for a + b.
//   MODE_SUB    : mode encoding for a - b.
//   addsub_op_t : one queued request {a, b, mode}.
package addsub_pkg;

  localparam int DATA_W = 32;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              mode;
  } addsub_op_t;

endpackage

// File: rtl/addsub_op_fifo.sv
// DEPTH-entry synchronous FIFO of addsub_op_t requests.
// The head entry is presented combinationally on rdata whenever count > 0.
// The caller guarantees push only when count < DEPTH and pop only when
// count > 0; this block does no overflow/underflow protection of its own.
// Ports:
//   clk, rstN : clock; asynchronous active-low reset (pointers and count).
//   push      : write wdata at the write pointer.
//   pop       : advance the read pointer past the head entry.
//   wdata     : entry to write.
//   rdata     : current head entry.
//   count     : number of occupied entries (0..DEPTH).
module addsub_op_fifo
  import addsub_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          push,
  input  logic          pop,
  input  addsub_op_t    wdata,
  output addsub_op_t    rdata,
  output logic [CW-1:0] count
);

  // Storage is not reset: stale entries are unreachable once the
  // pointers and count are cleared.
  addsub_op_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/addsub_operand_issue.sv
// Operand staging stage in front of the registered 32-bit adder/subtractor.
// Requests are queued in a small FIFO and issued one per cycle into
// registers that drive the adder inputs directly (same clock domain, so
// no synchronisers are needed). res_valid is issue_valid delayed by one
// cycle so it lines up with the adder's registered sum.
// Ports:
//   clk, rstN   : clock; asynchronous active-low reset.
//   in_valid    : request valid.
//   in_ready    : FIFO has room (state only, independent of in_valid/stall).
//   in_a, in_b  : operands.
//   in_mode     : 0 = add, 1 = subtract.
//   stall       : downstream consumer not ready; blocks issue.
//   issue_a/b   : registered operands to the adder.
//   issue_mode  : registered mode to the adder.
//   issue_valid : issue_* carries a newly issued operation this cycle.
//   res_valid   : adder sum valid this cycle.
//   count       : FIFO occupancy.
//   issue_cnt   : issued-operation counter, wraps modulo 2^CNT_W.
module addsub_operand_issue
  import addsub_pkg::*;
#(
  parameter int DATA_W = 32,  // must equal addsub_pkg::DATA_W
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_mode,
  input  logic              stall,
  output logic [DATA_W-1:0] issue_a,
  output logic [DATA_W-1:0] issue_b,
  output logic              issue_mode,
  output logic              issue_valid,
  output logic              res_valid,
  output logic [CW-1:0]     count,
  output logic [CNT_W-1:0]  issue_cnt
);

  addsub_op_t in_op_p0;
  addsub_op_t head_op_p0;
  addsub_op_t issue_op_p1;
  logic       push;
  logic       pop;
  logic       vld_p1;
  logic       vld_p2;

  // No pass-through: a full FIFO refuses input even if it pops this cycle.
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = !stall && (count != '0);

  assign in_op_p0 = '{a: in_a, b: in_b, mode: in_mode};

  addsub_op_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstN  (rstN),
    .push  (push),
    .pop   (pop),
    .wdata (in_op_p0),
    .rdata (head_op_p0),
    .count (count)
  );

  // ---- p0 -> p1: issue registers driving the adder inputs ----
  // ---- p1 -> p2: valid follows the adder's own output register ----
  // Operands hold while stalled so the adder keeps a stable input, but
  // vld_p1 drops, which prevents a duplicate res_valid.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      issue_op_p1 <= '0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      issue_cnt   <= '0;
    end else begin
      vld_p1 <= pop;
      vld_p2 <= vld_p1;
      if (pop) begin
        issue_op_p1 <= head_op_p0;
        issue_cnt   <= issue_cnt + 1'b1;
      end
    end
  end

  assign issue_a     = issue_op_p1.a;
  assign issue_b     = issue_op_p1.b;
  assign issue_mode  = issue_op_p1.mode;
  assign issue_valid = vld_p1;
  assign res_valid   = vld_p2;

endmodule

// File: tb/tb_addsub_operand_issue.sv
module tb_addsub_operand_issue;
  import addsub_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic          clk;
  logic          rstN;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_mode;
  logic          stall;
  logic [DW-1:0] issue_a;
  logic [DW-1:0] issue_b;
  logic          issue_mode;
  logic          issue_valid;
  logic          res_valid;
  logic [2:0]    count;
  logic [CNT_W-1:0] issue_cnt;

  addsub_operand_issue #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_mode     (in_mode),
    .stall       (stall),
    .issue_a     (issue_a),
    .issue_b     (issue_b),
    .issue_mode  (issue_mode),
    .issue_valid (issue_valid),
    .res_valid   (res_valid),
    .count       (count),
    .issue_cnt   (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural registered adder downstream of the DUT.
  logic [DW-1:0] sum;
  always @(posedge clk) begin
    sum <= (issue_mode == MODE_SUB) ? (issue_a - issue_b) : (issue_a + issue_b);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected issue entries and expected sums, pushed when a
  // request will be accepted, popped when the DUT issues / signals result.
  logic [DW*2:0]  iss_q[$];
  logic [DW-1:0]  res_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;

  always @(negedge clk) begin
    logic [DW*2:0] e;
    if (!rstN) begin
      iss_q.delete();
      res_q.delete();
      exp_cnt = '0;
    end else begin
      if (issue_valid) begin
        if (iss_q.size() == 0) begin
          chk("issue_stray", 1, 0);
        end else begin
          e = iss_q.pop_front();
          chk("issue_op", {issue_a, issue_b, issue_mode}, e);
          exp_cnt = exp_cnt + 1'b1;
          chk("issue_cnt", issue_cnt, exp_cnt);
        end
      end
      if (res_valid) begin
        if (res_q.size() == 0) begin
          chk("res_stray", 1, 0);
        end else begin
          chk("res_sum", sum, res_q.pop_front());
        end
      end
      // Inputs are stable here and will be taken at the next rising edge.
      if (in_valid && in_ready) begin
        iss_q.push_back({in_a, in_b, in_mode});
        res_q.push_back(in_mode ? (in_a - in_b) : (in_a + in_b));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic m);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
  endtask

  initial begin
    int acc;
    logic [DW-1:0] held;

    rstN = 1'b0;
    stall = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    step();
    step();
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_issue_cnt", issue_cnt, 0);
    chk("rst_issue_a", issue_a, 0);
    rstN = 1'b1;
    step();

    // Single add: 5 + 3
    drive(1'b1, 32'd5, 32'd3, MODE_ADD);
    step();                                   // E0
    drive(1'b0, '0, '0, 1'b0);
    step();                                   // E1
    chk("add_issue_valid", issue_valid, 1);
    chk("add_issue_a", issue_a, 5);
    chk("add_issue_b", issue_b, 3);
    chk("add_res_early", res_valid, 0);
    step();                                   // E2
    chk("add_res_valid", res_valid, 1);
    chk("add_sum", sum, 8);
    chk("add_issue_valid_off", issue_valid, 0);
    step();
    chk("add_res_once", res_valid, 0);

    // Subtract wrap: 0 - 1
    drive(1'b1, 32'd0, 32'd1, MODE_SUB);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("sub_issue_mode", issue_mode, 1);
    step();
    chk("sub_res_valid", res_valid, 1);
    chk("sub_sum", sum, 32'hFFFF_FFFF);
    step();

    // Fill under stall: 5 offers, 4 accepted
    stall = 1'b1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h100 + i, 32'h10 * i, i[0]);
      if (in_ready) acc++;
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    chk("fill_accepted", acc, 4);
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_stalled_valid", issue_valid, 0);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_issue_valid", issue_valid, 1);
      chk("drain_issue_a", issue_a, 32'h100 + i);
    end
    step();
    chk("drain_done_valid", issue_valid, 0);
    chk("drain_in_ready", in_ready, 1);
    chk("drain_count", count, 0);
    step();
    step();

    // Stall mid-stream for 2 cycles
    held = '0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h2000 + i, 32'h7 + i, i[1]);
      stall = (i == 3 || i == 4);
      if (stall) held = issue_a;
      step();
      if (i == 3 || i == 4) begin
        chk("stall_issue_valid", issue_valid, 0);
        chk("stall_issue_a_held", issue_a, held);
      end
    end
    drive(1'b0, '0, '0, 1'b0);
    stall = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("stream_iss_left", iss_q.size(), 0);
    chk("stream_res_left", res_q.size(), 0);

    // Reset mid-burst with 3 entries queued
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000 + i, 32'h1, MODE_ADD);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    chk("pre_rst_count", count, 3);
    #2;
    rstN = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_issue_valid", issue_valid, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_issue_cnt", issue_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    step();
    rstN = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_no_issue", issue_valid, 0);
      chk("post_rst_no_res", res_valid, 0);
    end

    // Counter wrap: 65536 issues return to 0, one more gives 1
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1, i, 32'hA5A5_0000 ^ i, i[2]);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    step();
    step();
    chk("wrap_cnt_zero", issue_cnt, 0);
    drive(1'b1, 32'h1234, 32'h34, MODE_SUB);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
    step();
    step();
    chk("wrap_cnt_one", issue_cnt, 1);
    chk("final_iss_left", iss_q.size(), 0);
    chk("final_res_left", res_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
